// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: glyph constants, capture FSM states and an anode-strobe
// helper shared by the 7-segment capture logic and future display encoders.
package seven_seg_pkg;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } cap_state_t;

    // Position of the lowest low bit of an active-low strobe vector (0 if none).
    // Callers pad unused upper bits with 1s.
    function automatic int onehot_low_idx(input logic [31:0] strobe_n);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (!strobe_n[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_to_hex.sv
// seg_to_hex: combinational active-low 7-segment glyph to hex nibble decoder.
// Unknown patterns (including blank) decode to nibble 0 with o_valid low.
module seg_to_hex
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_valid,
    output logic [3:0] o_nibble
);

    // Glyph lookup; anything not in the hex set is flagged invalid
    always_comb begin
        o_valid  = 1'b1;
        o_nibble = 4'h0;
        case (i_seg)
            SEG_0:   o_nibble = 4'h0;
            SEG_1:   o_nibble = 4'h1;
            SEG_2:   o_nibble = 4'h2;
            SEG_3:   o_nibble = 4'h3;
            SEG_4:   o_nibble = 4'h4;
            SEG_5:   o_nibble = 4'h5;
            SEG_6:   o_nibble = 4'h6;
            SEG_7:   o_nibble = 4'h7;
            SEG_8:   o_nibble = 4'h8;
            SEG_9:   o_nibble = 4'h9;
            SEG_A:   o_nibble = 4'hA;
            SEG_B:   o_nibble = 4'hB;
            SEG_C:   o_nibble = 4'hC;
            SEG_D:   o_nibble = 4'hD;
            SEG_E:   o_nibble = 4'hE;
            SEG_F:   o_nibble = 4'hF;
            default: o_valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: watches a multiplexed active-low 7-segment scan bus and
// rebuilds the hex value of each digit, with per-digit validity, frame
// completion and scan-error pulses.
// Optional feature: define SEVEN_SEG_CAPTURE_RAW_EN to add raw_seg_out, the
// raw synced cathode pattern of each digit's last capture.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   anode_in,
    input  logic [6:0]              seg_in,
    output logic [4*NUM_DIGITS-1:0] digit_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    scan_error
`ifdef SEVEN_SEG_CAPTURE_RAW_EN
    ,
    output logic [7*NUM_DIGITS-1:0] raw_seg_out
`endif
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PROG_W = $clog2(NUM_DIGITS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PROG_W-1:0] LAST_PROG = PROG_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(SETTLE_CYCLES);

    logic [NUM_DIGITS-1:0] r_a_meta, r_a_s, r_a_prev;
    logic [6:0]            r_s_meta, r_s_s, r_s_prev;
    cap_state_t            r_state, w_state_next, w_judge_state;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next, w_judge_cnt;
    logic [IDX_W-1:0]      r_expected;
    logic [PROG_W-1:0]     r_progress;
    logic                  r_frame, r_err;

    logic [NUM_DIGITS-1:0] w_zeros;
    logic                  w_any_low, w_onehot, w_multi;
    logic                  w_a_changed, w_s_changed;
    logic                  w_judge_err, w_capture, w_anode_err;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_glyph_ok;
    logic [3:0]            w_nibble;

    // Two-flop synchronizers plus one more stage to detect cycle-to-cycle changes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_meta <= '1;
            r_a_s    <= '1;
            r_a_prev <= '1;
            r_s_meta <= SEG_BLANK;
            r_s_s    <= SEG_BLANK;
            r_s_prev <= SEG_BLANK;
        end else begin
            r_a_meta <= anode_in;
            r_a_s    <= r_a_meta;
            r_a_prev <= r_a_s;
            r_s_meta <= seg_in;
            r_s_s    <= r_s_meta;
            r_s_prev <= r_s_s;
        end
    end

    assign w_zeros     = ~r_a_s;
    assign w_any_low   = |w_zeros;
    assign w_onehot    = w_any_low && ((w_zeros & (w_zeros - NUM_DIGITS'(1))) == '0);
    assign w_multi     = w_any_low && !w_onehot;
    assign w_a_changed = (r_a_s != r_a_prev);
    assign w_s_changed = (r_s_s != r_s_prev);
    assign w_idx       = IDX_W'(onehot_low_idx({{(32 - NUM_DIGITS){1'b1}}, r_a_s}));
    // A multi-low strobe is reported once, when it first appears
    assign w_judge_err = w_multi && w_a_changed;

    seg_to_hex u_seg_to_hex (
        .i_seg    (r_s_s),
        .o_valid  (w_glyph_ok),
        .o_nibble (w_nibble)
    );

    // Fresh judgement of the anode vector: one strobe starts a settle count
    always_comb begin
        w_judge_state = IDLE;
        w_judge_cnt   = '0;
        if (w_onehot) begin
            w_judge_state = SETTLE;
            w_judge_cnt   = CNT_W'(1);
        end
    end

    // Next-state logic: settle, capture once, then hold until the strobe moves
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_anode_err  = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = w_judge_state;
                w_cnt_next   = w_judge_cnt;
                w_anode_err  = w_judge_err;
            end
            SETTLE: begin
                if (w_a_changed || w_s_changed) begin
                    w_state_next = w_judge_state;
                    w_cnt_next   = w_judge_cnt;
                    w_anode_err  = w_judge_err;
                end else if (r_cnt >= CNT_DONE) begin
                    w_capture    = 1'b1;
                    w_state_next = HOLD;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (w_a_changed) begin
                    w_state_next = w_judge_state;
                    w_cnt_next   = w_judge_cnt;
                    w_anode_err  = w_judge_err;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // FSM state and settle counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Scan-order tracking; frame_done only on a fully in-order 0..N-1 sequence
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_expected <= '0;
            r_progress <= '0;
            r_frame    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            r_err   <= w_anode_err;
            if (w_capture) begin
                if (w_idx != r_expected) begin
                    r_err      <= 1'b1;
                    r_progress <= (w_idx == '0) ? PROG_W'(1) : '0;
                    r_expected <= (w_idx == LAST_IDX) ? '0 : w_idx + IDX_W'(1);
                end else if (w_idx == LAST_IDX) begin
                    r_frame    <= (r_progress == LAST_PROG);
                    r_progress <= '0;
                    r_expected <= '0;
                end else begin
                    r_progress <= (w_idx == '0) ? PROG_W'(1) : r_progress + PROG_W'(1);
                    r_expected <= w_idx + IDX_W'(1);
                end
            end
        end
    end

    assign frame_done = r_frame;
    assign scan_error = r_err;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic       w_sel;
            logic [3:0] r_nib;
            logic       r_vld;

            assign w_sel = w_capture && (w_idx == IDX_W'(gi));

            // Per-digit capture register, written only when this digit is strobed
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_nib <= 4'h0;
                    r_vld <= 1'b0;
                end else if (w_sel) begin
                    r_nib <= w_nibble;
                    r_vld <= w_glyph_ok;
                end
            end

            assign digit_out[4*gi +: 4] = r_nib;
            assign digit_valid[gi]      = r_vld;

`ifdef SEVEN_SEG_CAPTURE_RAW_EN
            logic [6:0] r_raw;

            // Raw cathode pattern kept alongside the decoded nibble
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_raw <= SEG_BLANK;
                end else if (w_sel) begin
                    r_raw <= r_s_s;
                end
            end

            assign raw_seg_out[7*gi +: 7] = r_raw;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed table, hand-written timing sequences and
// randomized scan traffic checked every cycle against a pin-level model.
`timescale 1ns/1ps
module tb_seven_seg_capture;

    localparam int N  = 4;
    localparam int SC = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  anode_in = 4'hF;
    logic [6:0]  seg_in   = 7'h7F;
    logic [15:0] digit_out;
    logic [3:0]  digit_valid;
    logic        frame_done, scan_error;
`ifdef SEVEN_SEG_CAPTURE_RAW_EN
    logic [27:0] raw_seg_out;
`endif

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    logic [6:0] glyph_tab [16];
    localparam logic [6:0] SEG_BAD = 7'b0110110;

    always #5 clk = ~clk;

    seven_seg_capture #(.NUM_DIGITS(4), .SETTLE_CYCLES(4), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .anode_in    (anode_in),
        .seg_in      (seg_in),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .scan_error  (scan_error)
`ifdef SEVEN_SEG_CAPTURE_RAW_EN
        ,
        .raw_seg_out (raw_seg_out)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (pin-level, two-cycle sync delay) -------------
    typedef struct packed {
        logic       cap;
        logic [1:0] idx;
        logic [3:0] nib;
        logic       vld;
        logic [6:0] raw;
        logic       err;
        logic       frame;
    } ev_t;

    ev_t         pipe0, pipe1, m_ev;
    logic [15:0] m_digit;
    logic [3:0]  m_valid;
    logic [27:0] m_raw;
    logic        m_frame, m_err;
    logic [3:0]  prev_a;
    logic [6:0]  prev_s;
    int          run_len, m_zeros, last_idx;
    bit          captured, in_order;
    int          hist[$];

    // Each pin sample becomes visible to the capture logic two edges later; a digit
    // is captured once per strobe when anode+seg have held for SC+1 samples.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe0 = '0; pipe1 = '0;
            m_digit = '0; m_valid = '0; m_frame = 0; m_err = 0;
            m_raw = {4{7'h7F}};
            prev_a = 4'hF; prev_s = 7'h7F;
            run_len = 0; captured = 0; last_idx = -1;
            hist.delete();
        end else begin
            m_frame = pipe1.frame;
            m_err   = pipe1.err;
            if (pipe1.cap) begin
                m_digit[pipe1.idx*4 +: 4] = pipe1.nib;
                m_valid[pipe1.idx]        = pipe1.vld;
                m_raw[pipe1.idx*7 +: 7]   = pipe1.raw;
            end
            pipe1 = pipe0;

            m_ev    = '0;
            m_zeros = $countones(~anode_in);
            if (anode_in == prev_a && seg_in == prev_s) run_len++;
            else run_len = 1;
            if (anode_in != prev_a) begin
                captured = 0;
                if (m_zeros > 1) m_ev.err = 1'b1;
            end
            if (m_zeros == 1 && !captured && run_len == SC + 1) begin
                captured = 1;
                m_ev.cap = 1'b1;
                for (int k = 0; k < N; k++) if (!anode_in[k]) m_ev.idx = 2'(k);
                m_ev.raw = seg_in;
                for (int k = 0; k < 16; k++) begin
                    if (glyph_tab[k] == seg_in) begin
                        m_ev.nib = 4'(k);
                        m_ev.vld = 1'b1;
                    end
                end
                if (int'(m_ev.idx) != ((last_idx < 0) ? 0 : (last_idx + 1) % N)) m_ev.err = 1'b1;
                last_idx = int'(m_ev.idx);
                hist.push_back(last_idx);
                if (hist.size() > N) void'(hist.pop_front());
                if (hist.size() == N) begin
                    in_order = 1;
                    for (int k = 0; k < N; k++) if (hist[k] != k) in_order = 0;
                    if (in_order) begin
                        m_ev.frame = 1'b1;
                        hist.delete();
                    end
                end
            end
            pipe0  = m_ev;
            prev_a = anode_in;
            prev_s = seg_in;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (model_on) begin
            chk("model_digit_out", 32'(digit_out), 32'(m_digit));
            chk("model_digit_valid", 32'(digit_valid), 32'(m_valid));
            chk("model_frame_done", 32'(frame_done), 32'(m_frame));
            chk("model_scan_error", 32'(scan_error), 32'(m_err));
`ifdef SEVEN_SEG_CAPTURE_RAW_EN
            chk("model_raw_seg_out", 32'(raw_seg_out), 32'(m_raw));
`endif
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  a;
        logic [6:0]  s;
        int          hold;
        logic [15:0] exp_d;
        logic [3:0]  exp_v;
        int          exp_f;
        int          exp_e;
    } vec_t;

    vec_t vt[14];

    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        @(negedge clk);
        anode_in = a;
        seg_in   = s;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf, ne, k;
        logic [3:0] a, last_a;
        logic [6:0] s;
        int ord, sel, hold, bi, bj;

        glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        vt[0]  = '{4'b1110, glyph_tab[1],  20, 16'h0001, 4'b0001, 0, 0};
        vt[1]  = '{4'b1101, glyph_tab[2],  20, 16'h0021, 4'b0011, 0, 0};
        vt[2]  = '{4'b1011, glyph_tab[3],  20, 16'h0321, 4'b0111, 0, 0};
        vt[3]  = '{4'b0111, glyph_tab[10], 20, 16'hA321, 4'b1111, 1, 0};
        vt[4]  = '{4'b1111, 7'h7F,         20, 16'hA321, 4'b1111, 0, 0};
        vt[5]  = '{4'b1100, glyph_tab[5],  20, 16'hA321, 4'b1111, 0, 1};
        vt[6]  = '{4'b1111, 7'h7F,         20, 16'hA321, 4'b1111, 0, 0};
        vt[7]  = '{4'b1110, glyph_tab[8],  20, 16'hA328, 4'b1111, 0, 0};
        vt[8]  = '{4'b1011, glyph_tab[15], 20, 16'hAF28, 4'b1111, 0, 1};
        vt[9]  = '{4'b0111, glyph_tab[12], 20, 16'hCF28, 4'b1111, 0, 0};
        vt[10] = '{4'b1110, glyph_tab[0],  20, 16'hCF20, 4'b1111, 0, 0};
        vt[11] = '{4'b1101, SEG_BAD,       20, 16'hCF00, 4'b1101, 0, 0};
        vt[12] = '{4'b1011, glyph_tab[7],  20, 16'hC700, 4'b1101, 0, 0};
        vt[13] = '{4'b0111, glyph_tab[14], 20, 16'hE700, 4'b1101, 1, 0};

        // Reset and idle state
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_digit_out", 32'(digit_out), 32'h0);
        chk("reset_digit_valid", 32'(digit_valid), 32'h0);
        chk("reset_pulses", 32'(frame_done) + 32'(scan_error), 32'h0);

        // Directed table: one strobe per record
        for (int r = 0; r < 14; r++) begin
            drive(vt[r].a, vt[r].s);
            nf = 0; ne = 0;
            for (int c = 0; c < vt[r].hold; c++) begin
                @(posedge clk); #1;
                if (frame_done) nf++;
                if (scan_error) ne++;
            end
            chk($sformatf("vec%0d_digit_out", r), 32'(digit_out), 32'(vt[r].exp_d));
            chk($sformatf("vec%0d_digit_valid", r), 32'(digit_valid), 32'(vt[r].exp_v));
            chk($sformatf("vec%0d_frames", r), 32'(nf), 32'(vt[r].exp_f));
            chk($sformatf("vec%0d_errors", r), 32'(ne), 32'(vt[r].exp_e));
            $display("vec %0d anode=%b seg=%b digit_out=%h valid=%b frames=%0d errs=%0d",
                     r, vt[r].a, vt[r].s, digit_out, digit_valid, nf, ne);
        end

        // Asynchronous reset in the middle of a settle count
        drive(4'b1110, glyph_tab[5]);
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset_digit_out", 32'(digit_out), 32'h0);
        chk("midreset_digit_valid", 32'(digit_valid), 32'h0);
        chk("midreset_pulses", 32'(frame_done) + 32'(scan_error), 32'h0);
`ifdef SEVEN_SEG_CAPTURE_RAW_EN
        chk("midreset_raw", 32'(raw_seg_out), 32'({4{7'h7F}}));
`endif
        drive(4'hF, 7'h7F);
        @(negedge clk);
        reset = 1'b1;
        nf = 0; ne = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (frame_done) nf++;
            if (scan_error) ne++;
        end
        chk("postreset_pulses", 32'(nf + ne), 32'h0);
        chk("postreset_digit_out", 32'(digit_out), 32'h0);
        $display("reset sequence digit_out=%h pulses=%0d", digit_out, nf + ne);

        // First capture after reset must be digit 0
        drive(4'b1101, glyph_tab[2]);
        ne = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (scan_error) ne++;
        end
        chk("postreset_order_err", 32'(ne), 32'h1);
        $display("post-reset digit1 first errs=%0d", ne);
        drive(4'hF, 7'h7F);
        repeat (5) @(posedge clk);

        // Capture latency from the anode change at the pins
        drive(4'b1110, glyph_tab[6]);
        k = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (digit_out[3:0] == 4'h6) begin
                k = c;
                break;
            end
        end
        chk("capture_latency", 32'(k), 32'(SC + 3));
        $display("latency strobe digit0 clocks=%0d", k);

        // Segment glitch during settle restarts the count
        drive(4'b1011, glyph_tab[9]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        seg_in = glyph_tab[11];
        k = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (digit_out[11:8] != 4'h0) begin
                k = c;
                break;
            end
        end
        chk("glitch_latency", 32'(k), 32'(SC + 3));
        chk("glitch_value", 32'(digit_out[11:8]), 32'hB);
        $display("glitch strobe digit2 clocks=%0d nibble=%h", k, digit_out[11:8]);

        // Strobe one cycle too short to be captured
        drive(4'b0111, glyph_tab[13]);
        repeat (SC - 1) @(posedge clk);
        drive(4'hF, 7'h7F);
        repeat (15) @(posedge clk);
        #1;
        chk("short_strobe_nibble", 32'(digit_out[15:12]), 32'h0);
        chk("short_strobe_valid", 32'(digit_valid[3]), 32'h0);
        $display("short strobe digit3 nibble=%h valid=%b", digit_out[15:12], digit_valid[3]);

        // Randomized scan traffic, checked by the model each cycle
        ord = 0;
        last_a = 4'hF;
        for (int r = 0; r < 400; r++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                a = ~(4'b0001 << ord);
                ord = (ord + 1) % N;
            end else if (sel == 5) begin
                a = ~(4'b0001 << $urandom_range(0, 3));
            end else if (sel == 6) begin
                a = 4'hF;
            end else if (sel == 7) begin
                bi = $urandom_range(0, 3);
                bj = (bi + 1 + $urandom_range(0, 2)) % N;
                a = ~((4'b0001 << bi) | (4'b0001 << bj));
            end else begin
                a = last_a;
            end
            s = ($urandom_range(0, 9) < 8) ? glyph_tab[$urandom_range(0, 15)] : 7'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 14);
            drive(a, s);
            last_a = a;
            repeat (hold - 1) @(posedge clk);
            if (r % 50 == 0)
                $display("random seg %0d anode=%b seg=%b hold=%0d digit_out=%h", r, a, s, hold, digit_out);
        end
        drive(4'hF, 7'h7F);
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
